// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC widths, sequencer state encoding and signed operand/accumulator types
package mac_pkg;
  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, OUT} seq_state_t;
  typedef logic signed [MAC_DATA_W-1:0] operand_t;
  typedef logic signed [MAC_ACC_W-1:0] acc_t;
endpackage

// File: rtl/vec_regfile.sv
// vec_regfile: K x DATA_W register file, reset to zero; ports clk/reset, write we/waddr/wdata (waddr>=K dropped), comb read raddr->rdata
module vec_regfile #(
  parameter int K = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W = $clog2(K)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [IDX_W-1:0]         waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]         raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [K];
  always_ff @(posedge clk)
    for (int i = 0; i < K; i++)
      if (reset) mem[i] <= '0;
      else if (we && int'(waddr) == i) mem[i] <= wdata;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < K; i++)
      if (int'(raddr) == i) rdata = mem[i];
  end
endmodule

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: loads A/B via ld_*, on start clears/feeds mac_unit K cycles, returns mac_acc on res_valid/res_ready
module dot_product_sequencer
  import mac_pkg::*;
#(
  parameter int K = 4,
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W = MAC_ACC_W,
  parameter int IDX_W = $clog2(K)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     ld_sel,
  input  logic [IDX_W-1:0]         ld_idx,
  input  logic signed [DATA_W-1:0] ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     mac_reset,
  output logic                     mac_enable,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_acc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data
);
  seq_state_t state, nxt;
  logic [IDX_W-1:0] cnt;
  logic signed [DATA_W-1:0] a_rd, b_rd;
  logic ld_fire;
  assign ld_ready = state == IDLE;
  assign ld_fire = ld_valid && ld_ready;
  assign busy = state != IDLE;
  assign mac_reset = reset || state == CLEAR;
  assign mac_enable = state == FEED;
  assign mac_a = mac_enable ? a_rd : '0;
  assign mac_b = mac_enable ? b_rd : '0;
  assign res_valid = state == OUT;
  vec_regfile #(.K(K), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_a (
    .clk(clk), .reset(reset), .we(ld_fire && !ld_sel), .waddr(ld_idx), .wdata(ld_data),
    .raddr(cnt), .rdata(a_rd)
  );
  vec_regfile #(.K(K), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_b (
    .clk(clk), .reset(reset), .we(ld_fire && ld_sel), .waddr(ld_idx), .wdata(ld_data),
    .raddr(cnt), .rdata(b_rd)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = FEED;
      FEED:    nxt = cnt == IDX_W'(K - 1) ? WAIT : FEED;
      WAIT:    nxt = OUT;
      OUT:     nxt = res_ready ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      res_data <= '0;
    end else begin
      state <= nxt;
      cnt <= state == FEED ? cnt + 1'b1 : '0;
      if (state == WAIT) res_data <= mac_acc;
    end
  end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: directed self-checking bench with a behavioural mac_unit
module tb_dot_product_sequencer;
  localparam int K = 4;
  logic clk = 0;
  logic reset = 1;
  logic ld_valid = 0, ld_sel = 0, start = 0, res_ready = 0;
  logic [2:0] ld_idx = '0;
  logic signed [7:0] ld_data = '0;
  logic ld_ready, busy, mac_reset, mac_enable, res_valid;
  logic signed [7:0] mac_a, mac_b;
  logic signed [31:0] mac_acc, res_data;
  int n_chk = 0, n_fail = 0;
  int ma [K], mb [K];
  int pa [8], pb [8];
  int lat, en;
  bit to;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mac_reset) mac_acc <= 0;
    else if (mac_enable) mac_acc <= mac_acc + 32'(mac_a) * 32'(mac_b);

  dot_product_sequencer #(.K(K), .DATA_W(8), .ACC_W(32), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_idx(ld_idx), .ld_data(ld_data), .start(start), .busy(busy), .mac_reset(mac_reset),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int idx, input int data);
    ld_valid = 1; ld_sel = sel; ld_idx = 3'(idx); ld_data = 8'(data);
    tick();
    ld_valid = 0;
    if (idx < K) begin
      if (sel) mb[idx] = data; else ma[idx] = data;
    end
  endtask

  task automatic load_vecs(input int a0, a1, a2, a3, b0, b1, b2, b3);
    load(0, 0, a0); load(0, 1, a1); load(0, 2, a2); load(0, 3, a3);
    load(1, 0, b0); load(1, 1, b1); load(1, 2, b2); load(1, 3, b3);
  endtask

  task automatic wait_result();
    lat = 0; en = 0; to = 0;
    forever begin
      tick();
      start = 0; ld_valid = 0;
      lat++;
      if (mac_enable && en < 8) begin pa[en] = int'(mac_a); pb[en] = int'(mac_b); en++; end
      if (res_valid) break;
      if (lat > 40) begin to = 1; break; end
    end
  endtask

  task automatic run();
    start = 1;
    wait_result();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (ld_ready !== 1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    n_chk++; if (mac_enable !== 0 || mac_a !== 0 || mac_b !== 0) begin n_fail++; $display("FAIL reset_mac got en=%b a=%0d b=%0d want 0 0 0", mac_enable, mac_a, mac_b); end
    n_chk++; if (res_valid !== 0 || res_data !== 0) begin n_fail++; $display("FAIL reset_res got v=%b d=%0d want 0 0", res_valid, res_data); end
    n_chk++; if (mac_reset !== 1) begin n_fail++; $display("FAIL reset_mac_reset got %b want 1", mac_reset); end
    reset = 0;
    tick();
    n_chk++; if (mac_reset !== 0 || busy !== 0) begin n_fail++; $display("FAIL post_reset got mac_reset=%b busy=%b want 0 0", mac_reset, busy); end
  endtask

  task automatic test_basic();
    load_vecs(-5, 1, 5, 2, 5, 3, 4, 6);
    run();
    n_chk++; if (to || lat !== 7) begin n_fail++; $display("FAIL basic_latency got %0d want 7", lat); end
    n_chk++; if (en !== 4) begin n_fail++; $display("FAIL basic_enable_cycles got %0d want 4", en); end
    n_chk++; if (res_data !== 10) begin n_fail++; $display("FAIL basic_result got %0d want 10", res_data); end
    for (int i = 0; i < K; i++) begin
      n_chk++; if (pa[i] !== ma[i] || pb[i] !== mb[i]) begin n_fail++; $display("FAIL basic_operands[%0d] got %0d,%0d want %0d,%0d", i, pa[i], pb[i], ma[i], mb[i]); end
    end
    n_chk++; if (busy !== 0 || res_valid !== 0) begin n_fail++; $display("FAIL basic_idle got busy=%b v=%b want 0 0", busy, res_valid); end
  endtask

  task automatic test_stall();
    start = 1;
    wait_result();
    n_chk++; if (to) begin n_fail++; $display("FAIL stall_timeout got none want res_valid"); end
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      n_chk++; if (res_valid !== 1 || res_data !== 10) begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b d=%0d want 1 10", i, res_valid, res_data); end
      n_chk++; if (busy !== 1 || ld_ready !== 0) begin n_fail++; $display("FAIL stall_flags[%0d] got busy=%b ld_ready=%b want 1 0", i, busy, ld_ready); end
      tick();
    end
    start = 0;
    res_ready = 1;
    tick();
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (busy !== 0 || res_valid !== 0 || mac_reset !== 0) begin n_fail++; $display("FAIL stall_no_queue[%0d] got busy=%b v=%b mrst=%b want 0 0 0", i, busy, res_valid, mac_reset); end
      tick();
    end
  endtask

  task automatic test_extremes();
    int av [3] = '{-128, -128, 0};
    int bv [3] = '{-128, 127, 77};
    int ex [3] = '{65536, -65024, 0};
    for (int c = 0; c < 3; c++) begin
      load_vecs(av[c], av[c], av[c], av[c], bv[c], bv[c], bv[c], bv[c]);
      run();
      n_chk++; if (to || res_data !== ex[c]) begin n_fail++; $display("FAIL extreme[%0d] got %0d want %0d", c, res_data, ex[c]); end
    end
  endtask

  task automatic test_reset_mid();
    load_vecs(-5, 1, 5, 2, 5, 3, 4, 6);
    start = 1;
    tick();
    start = 0;
    tick(); tick();
    n_chk++; if (mac_enable !== 1) begin n_fail++; $display("FAIL mid_feed got en=%b want 1", mac_enable); end
    reset = 1;
    tick();
    n_chk++; if (busy !== 0 || ld_ready !== 1 || mac_enable !== 0 || mac_a !== 0 || mac_b !== 0) begin n_fail++; $display("FAIL mid_reset_outs got busy=%b rdy=%b en=%b a=%0d b=%0d want 0 1 0 0 0", busy, ld_ready, mac_enable, mac_a, mac_b); end
    n_chk++; if (res_valid !== 0 || res_data !== 0 || mac_reset !== 1) begin n_fail++; $display("FAIL mid_reset_res got v=%b d=%0d mrst=%b want 0 0 1", res_valid, res_data, mac_reset); end
    reset = 0;
    for (int i = 0; i < K; i++) begin ma[i] = 0; mb[i] = 0; end
    tick();
    run();
    n_chk++; if (to || res_data !== 0) begin n_fail++; $display("FAIL mid_rerun got %0d want 0", res_data); end
  endtask

  task automatic test_load_with_start();
    load_vecs(-5, 1, 5, 2, 5, 3, 4, 6);
    n_chk++; if (ld_ready !== 1) begin n_fail++; $display("FAIL ls_ready got %b want 1", ld_ready); end
    ld_valid = 1; ld_sel = 0; ld_idx = 3; ld_data = 7; ma[3] = 7;
    run();
    n_chk++; if (to || res_data !== 40) begin n_fail++; $display("FAIL load_with_start got %0d want 40", res_data); end
    ld_valid = 1; ld_sel = 0; ld_idx = 5; ld_data = 99;
    n_chk++; if (ld_ready !== 1) begin n_fail++; $display("FAIL oob_handshake got %b want 1", ld_ready); end
    tick();
    ld_sel = 1; ld_idx = 4; ld_data = -99;
    tick();
    ld_valid = 0;
    run();
    n_chk++; if (to || res_data !== 40) begin n_fail++; $display("FAIL oob_dropped got %0d want 40", res_data); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    res_ready = 1;
    start = 1;
    wait_result();
    t1 = lat;
    n_chk++; if (to || res_data !== 40) begin n_fail++; $display("FAIL b2b_first got %0d want 40", res_data); end
    tick();
    n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    start = 1;
    wait_result();
    t2 = 1 + lat;
    n_chk++; if (to || t2 !== K + 4) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d (first lat %0d)", t2, K + 4, t1); end
    n_chk++; if (res_data !== 40) begin n_fail++; $display("FAIL b2b_second got %0d want 40", res_data); end
    for (int i = 0; i < K; i++) begin
      n_chk++; if (pa[i] !== ma[i] || pb[i] !== mb[i]) begin n_fail++; $display("FAIL b2b_operands[%0d] got %0d,%0d want %0d,%0d", i, pa[i], pb[i], ma[i], mb[i]); end
    end
    tick();
    res_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_extremes();
    test_reset_mid();
    test_load_with_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
